clint_timer: RTL and testbench

//  Parametrised successor of the single-hart machine timer: a CLINT-style block on the

---
 rtl/clint_timer.sv | 185 ++++++++++++++++++
 tb/tb_clint_timer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// CLINT-style machine timer: 64-bit mtime with prescaler, per-hart
// mtimecmp/msip on a Wishbone slave, registered MTIP/MSIP outputs.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   wb_adr_i[15:0]       byte address (bits [1:0] ignored)
//   wb_dat_i / wb_dat_o  write data in / registered read data out
//   wb_sel_i, wb_we_i    byte lanes, write enable
//   wb_stb_i, wb_cyc_i   strobe, cycle; wb_ack_o one-cycle acknowledge
//   timer_irq_o          per-hart MTIP
//   soft_irq_o           per-hart MSIP
module clint_timer #(
  parameter int N_HARTS  = 1,
  parameter int PRESCALE = 0,
  parameter int PS_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [15:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic [N_HARTS-1:0] timer_irq_o,
  output logic [N_HARTS-1:0] soft_irq_o
);

  function automatic logic [31:0] merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  logic [63:0]        mtime_q, mtime_d;
  logic [PS_W-1:0]    pcnt_q, pcnt_d;
  logic [PS_W-1:0]    div_q, div_d;
  logic               en_q, en_d;
  logic [63:0]        cmp_q [N_HARTS];
  logic [63:0]        cmp_d [N_HARTS];
  logic [N_HARTS-1:0] msip_q, msip_d;
  logic [N_HARTS-1:0] tirq_q, sirq_q;
  logic               ack_q;
  logic [31:0]        dat_q;

  logic        req, wr;
  logic        dec_msip, dec_cmp, dec_ctrl;
  logic        dec_lo, dec_hi;
  logic [3:0]  h_msip, h_cmp;
  logic        cmp_hi;
  logic [31:0] ctrl_rd, ctrl_w;
  logic [31:0] rdata;
  logic        tick, div_wr;
  logic        unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];

  assign req = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr  = req & wb_we_i;

  // 0x0000-0x003F msip, 0x4000-0x407F mtimecmp
  assign dec_msip = (wb_adr_i[15:6] == 10'h000);
  assign dec_cmp  = (wb_adr_i[15:7] == 9'h080);
  assign dec_ctrl = (wb_adr_i[15:2] == 14'h2FFC);
  assign dec_lo   = (wb_adr_i[15:2] == 14'h2FFE);
  assign dec_hi   = (wb_adr_i[15:2] == 14'h2FFF);
  assign h_msip   = wb_adr_i[5:2];
  assign h_cmp    = wb_adr_i[6:3];
  assign cmp_hi   = wb_adr_i[2];

  assign ctrl_rd = 32'(en_q) | (32'(div_q) << 16);
  assign ctrl_w  = merge(ctrl_rd, wb_dat_i, wb_sel_i);
  assign div_wr  = wr & dec_ctrl & (|wb_sel_i[3:2]);
  assign tick    = en_q & (pcnt_q == div_q);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      dec_msip: begin
        for (int h = 0; h < N_HARTS; h++)
          if (h_msip == 4'(h)) rdata[0] = msip_q[h];
      end
      dec_cmp: begin
        for (int h = 0; h < N_HARTS; h++)
          if (h_cmp == 4'(h))
            rdata = cmp_hi ? cmp_q[h][63:32]
                           : cmp_q[h][31:0];
      end
      dec_ctrl: rdata = ctrl_rd;
      dec_lo:   rdata = mtime_q[31:0];
      dec_hi:   rdata = mtime_q[63:32];
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    en_d   = en_q;
    div_d  = div_q;
    msip_d = msip_q;
    for (int h = 0; h < N_HARTS; h++)
      cmp_d[h] = cmp_q[h];

    if (wr & dec_ctrl) begin
      en_d = ctrl_w[0];
      if (|wb_sel_i[3:2]) div_d = ctrl_w[16 +: PS_W];
    end

    for (int h = 0; h < N_HARTS; h++) begin
      if (wr & dec_msip & (h_msip == 4'(h)))
        msip_d[h] = wb_sel_i[0] ? wb_dat_i[0] : msip_q[h];
      if (wr & dec_cmp & (h_cmp == 4'(h))) begin
        if (cmp_hi)
          cmp_d[h][63:32] =
            merge(cmp_q[h][63:32], wb_dat_i, wb_sel_i);
        else
          cmp_d[h][31:0] =
            merge(cmp_q[h][31:0], wb_dat_i, wb_sel_i);
      end
    end
  end

  always_comb begin
    pcnt_d = pcnt_q;
    if (div_wr)
      pcnt_d = '0;
    else if (en_q)
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
  end

  // A bus write to either half beats a tick; no carry across halves.
  always_comb begin
    mtime_d = mtime_q;
    if (wr & dec_lo)
      mtime_d[31:0] =
        merge(mtime_q[31:0], wb_dat_i, wb_sel_i);
    else if (wr & dec_hi)
      mtime_d[63:32] =
        merge(mtime_q[63:32], wb_dat_i, wb_sel_i);
    else if (tick)
      mtime_d = mtime_q + 64'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtime_q <= '0;
      pcnt_q  <= '0;
      div_q   <= PS_W'(PRESCALE);
      en_q    <= 1'b1;
      msip_q  <= '0;
      tirq_q  <= '0;
      sirq_q  <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      for (int h = 0; h < N_HARTS; h++)
        cmp_q[h] <= '1;
    end else begin
      mtime_q <= mtime_d;
      pcnt_q  <= pcnt_d;
      div_q   <= div_d;
      en_q    <= en_d;
      msip_q  <= msip_d;
      sirq_q  <= msip_q;
      ack_q   <= req;
      if (req) dat_q <= wb_we_i ? '0 : rdata;
      for (int h = 0; h < N_HARTS; h++) begin
        cmp_q[h]  <= cmp_d[h];
        tirq_q[h] <= (mtime_q >= cmp_q[h]);
      end
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign timer_irq_o = tirq_q;
  assign soft_irq_o  = sirq_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: directed scenarios plus random bus traffic,
// checked every cycle against a register-map level model.
module tb_clint_timer;
  localparam int NH = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic [NH-1:0] tirq_o, sirq_o;

  always #5 clk = ~clk;

  clint_timer #(.N_HARTS(NH), .PRESCALE(0), .PS_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .wb_adr_i(adr),
    .wb_dat_i(wdat), .wb_sel_i(sel), .wb_we_i(we),
    .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_dat_o(dat_o),
    .wb_ack_o(ack_o), .timer_irq_o(tirq_o),
    .soft_irq_o(sirq_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_time;
  logic [63:0] m_cmp [NH];
  logic [NH-1:0] m_msip;
  logic        m_en;
  logic [15:0] m_div, m_pcnt;
  logic        m_live = 1'b0;
  logic        exp_ack, exp_rd;
  logic [31:0] exp_dat;
  logic [NH-1:0] exp_tirq, exp_sirq;
  logic        r_req, r_tick, r_clr, r_twr, r_en0;
  logic [31:0] r_nv;
  logic [15:0] r_a;
  int          r_h;

  function automatic logic [31:0] mmerge(logic [31:0] o, logic [31:0] n,
                                         logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(logic [15:0] a_in);
    logic [15:0] a = {a_in[15:2], 2'b00};
    int h;
    if (a < 16'h0040) begin
      h = a / 4;
      return (h < NH) ? {31'b0, m_msip[h]} : 32'h0;
    end
    if (a >= 16'h4000 && a < 16'h4080) begin
      h = (a - 16'h4000) / 8;
      if (h >= NH) return 32'h0;
      return a[2] ? m_cmp[h][63:32] : m_cmp[h][31:0];
    end
    if (a == 16'hBFF0) return {m_div, 15'b0, m_en};
    if (a == 16'hBFF8) return m_time[31:0];
    if (a == 16'hBFFC) return m_time[63:32];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!rst_ni) begin
      m_time = 0; m_msip = 0; m_en = 1; m_div = 0; m_pcnt = 0;
      for (int h = 0; h < NH; h++) m_cmp[h] = '1;
      exp_ack = 0; exp_rd = 0; exp_dat = 0;
      exp_tirq = 0; exp_sirq = 0; m_live = 1;
    end else begin
      for (int h = 0; h < NH; h++)
        exp_tirq[h] = (m_time >= m_cmp[h]);
      exp_sirq = m_msip;
      r_req  = stb && cyc && !exp_ack;
      r_tick = m_en && (m_pcnt == m_div);
      r_en0  = m_en;
      r_clr  = 0; r_twr = 0;
      exp_rd = r_req && !we;
      if (exp_rd) exp_dat = mread(adr);
      if (r_req && we) begin
        r_nv = mmerge(mread(adr), wdat, sel);
        r_a  = {adr[15:2], 2'b00};
        if (r_a < 16'h0040) begin
          r_h = r_a / 4;
          if (r_h < NH) m_msip[r_h] = r_nv[0];
        end else if (r_a >= 16'h4000 && r_a < 16'h4080) begin
          r_h = (r_a - 16'h4000) / 8;
          if (r_h < NH) begin
            if (r_a[2]) m_cmp[r_h][63:32] = r_nv;
            else        m_cmp[r_h][31:0]  = r_nv;
          end
        end else if (r_a == 16'hBFF0) begin
          m_en = r_nv[0];
          if (sel[3] || sel[2]) begin
            m_div = r_nv[31:16];
            r_clr = 1;
          end
        end else if (r_a == 16'hBFF8) begin
          m_time[31:0] = r_nv; r_twr = 1;
        end else if (r_a == 16'hBFFC) begin
          m_time[63:32] = r_nv; r_twr = 1;
        end
      end
      if (r_clr) m_pcnt = 0;
      else if (r_en0) m_pcnt = r_tick ? 16'd0 : m_pcnt + 16'd1;
      if (r_tick && !r_twr) m_time = m_time + 64'd1;
      exp_ack = r_req;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      chk("ack", 64'(ack_o), 64'(exp_ack));
      chk("timer_irq", 64'(tirq_o), 64'(exp_tirq));
      chk("soft_irq", 64'(sirq_o), 64'(exp_sirq));
      if (exp_ack && exp_rd) chk("rdata", 64'(dat_o), 64'(exp_dat));
    end
  end

  // ---------------- bus master ----------------
  task automatic bus(input logic w, input logic [15:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r);
    int n = 0;
    stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_o && n < 4);
    checks++;
    if (!ack_o) begin
      failures++;
      $display("FAIL ack_timeout actual=0 expected=1 adr=%h", a);
    end
    r = dat_o;
    stb = 0; cyc = 0; we = 0;
    @(negedge clk);
  endtask

  task automatic wr32(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, d, 4'hF, dummy);
  endtask

  logic [31:0] rd, v;
  logic [15:0] atab [17] = '{
    16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010,
    16'h4000, 16'h4004, 16'h4008, 16'h400C, 16'h4018,
    16'h401C, 16'h4020, 16'hBFF0, 16'hBFF4, 16'hBFF8,
    16'hBFFC, 16'h1234};

  initial begin
    repeat (3) @(negedge clk);
    rst_ni = 1;
    bus(0, 16'hBFF8, 0, 4'hF, rd);
    chk("reset_mtime_lo", 64'(rd), 64'h0);
    bus(0, 16'h4000, 0, 4'hF, rd);
    chk("reset_cmp0_lo", 64'(rd), 64'hFFFF_FFFF);

    // compare/interrupt timing
    wr32(16'hBFF0, 32'h0);
    wr32(16'hBFF8, 32'h0);
    wr32(16'hBFFC, 32'h0);
    wr32(16'h4000, 32'd10);
    wr32(16'h4004, 32'h0);
    wr32(16'hBFF0, 32'h1);
    repeat (9) @(negedge clk);
    chk("tirq_before_10", 64'(tirq_o[0]), 64'h0);
    @(negedge clk);
    chk("tirq_at_10", 64'(tirq_o[0]), 64'h1);
    wr32(16'h4000, 32'd20);
    chk("tirq_fall", 64'(tirq_o[0]), 64'h0);

    // low-to-high carry
    wr32(16'hBFF0, 32'h0);
    wr32(16'hBFF8, 32'hFFFF_FFFE);
    wr32(16'hBFFC, 32'h0);
    wr32(16'hBFF0, 32'h1);
    wr32(16'hBFF0, 32'h0);
    bus(0, 16'hBFF8, 0, 4'hF, rd);
    chk("carry_lo", 64'(rd), 64'h0);
    bus(0, 16'hBFFC, 0, 4'hF, rd);
    chk("carry_hi", 64'(rd), 64'h1);

    // prescaler and freeze
    bus(0, 16'hBFF8, 0, 4'hF, v);
    wr32(16'hBFF0, 32'h0003_0001);
    repeat (6) @(negedge clk);
    wr32(16'hBFF0, 32'h0003_0000);
    bus(0, 16'hBFF8, 0, 4'hF, rd);
    chk("prescale_div3", 64'(rd), 64'(v + 32'd2));
    repeat (20) @(negedge clk);
    bus(0, 16'hBFF8, 0, 4'hF, rd);
    chk("frozen", 64'(rd), 64'(v + 32'd2));

    // software interrupt and out-of-range hart
    wr32(16'h0008, 32'h1);
    chk("msip2", 64'(sirq_o), 64'h4);
    bus(0, 16'h0010, 0, 4'hF, rd);
    chk("hart4_read", 64'(rd), 64'h0);
    wr32(16'h0008, 32'h0);

    // write vs tick collision, byte lanes
    wr32(16'hBFF0, 32'h1);
    wr32(16'hBFF8, 32'd5);
    wr32(16'hBFF0, 32'h0);
    bus(0, 16'hBFF8, 0, 4'hF, rd);
    chk("collision", 64'(rd), 64'd7);
    wr32(16'h4008, 32'h1234_5678);
    bus(1, 16'h4008, 32'h0000_00AB, 4'b0001, rd);
    bus(0, 16'h4008, 0, 4'hF, rd);
    chk("byte_lane", 64'(rd), 64'h1234_56AB);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      logic [31:0] d;
      int k;
      if (i == 200) begin
        stb = 1; cyc = 1; we = 0; adr = 16'hBFF8;
        @(negedge clk);
        rst_ni = 0;
        repeat (2) @(negedge clk);
        rst_ni = 1; stb = 0; cyc = 0;
        @(negedge clk);
      end
      if ($urandom_range(0, 4) == 0) begin
        stb = 1'($urandom); cyc = 0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        stb = 0;
        continue;
      end
      k = $urandom_range(0, 16);
      a = atab[k] | 16'($urandom_range(0, 3));
      d = $urandom;
      case (atab[k])
        16'hBFF0: d = {14'b0, 2'($urandom), 15'b0,
                       1'($urandom_range(0, 3) != 0)};
        16'h4000, 16'h4008, 16'h4018:
          if ($urandom_range(0, 1) == 1)
            d = m_time[31:0] + 32'($urandom_range(0, 40));
        16'h4004, 16'h400C, 16'h401C:
          d = $urandom_range(0, 1) ? m_time[63:32] : 32'hFFFF_FFFF;
        16'hBFFC:
          if ($urandom_range(0, 3) != 0) d = 0;
        default: ;
      endcase
      bus(1'($urandom), a, d,
          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
